round_scheduler: RTL and testbench
==================================

# round_scheduler

Session-level controller that sequences the three BitBakery minigames (memory, cake, clothes) into a multi-round session. It selects the game for each round, enforces the inter-round interval, issues the one-cycle `jogar` start pulse, waits for the selected game's `pronto` or a timeout, and accumulates a saturating session score. It sits between the top-level menu FSM and the per-game cores, driving the output mux select.

## Interface
- `ROUNDS`, default 3: rounds per session, minimum 1.
- `INTERVAL_CYCLES`, default 2000: interval length in cycles before each round, minimum 1.
- `TIMEOUT_CYCLES`, default 60000: maximum RUN length in cycles before the round is forced to end.
- `SCORE_W`, default 8: width of the accumulated score.

Ports (clock and reset first):
- `clock` input 1: system clock (divided game clock).
- `reset` input 1: reset, asynchronous, active-high.
- `iniciar` input 1: session start request, level.
- `modo` input 1: 0 = fixed order 0,1,2,0,…; 1 = pseudo-random order.
- `dificuldade` input 1: difficulty, latched at session start.
- `pronto` input 3: per-game done flags, where bit i belongs to game i.
- `pontuacao_0`, `pontuacao_1`, `pontuacao_2` input 3 each: per-game round scores.
- `game_sel` output 2: selected game (0..2); also drives the output mux.
- `jogar` output 1: one-cycle start pulse to the games.
- `dificuldade_out` output 1: latched difficulty.
- `rodada` output 4: current round number, 1-based; 0 when idle.
- `score` output SCORE_W: accumulated session score.
- `timeout_flag` output 1: sticky; set if any round timed out.
- `sessao_fim` output 1: high while in DONE.
- `estado` output 4: state code.

## Operation
- **States and codes:** IDLE 0, SELECT 1, INTERVAL 2, START 3, RUN 4, SCORE 5, CHECK 6, DONE 7. Unused codes go to IDLE.
- **IDLE:** when `iniciar`=1, latch `dificuldade` and `modo`, clear `score`, `rodada`, `timeout_flag` and `last_game`, then go to SELECT.
- **SELECT (1 cycle):** increment `rodada` and choose `game_sel`.
  - Fixed mode: 0, 1, 2, 0, … starting at 0 each session.
  - Random mode: `cand` = LFSR[1:0], with 3 mapped to 0. If `cand` equals `last_game`, use `(last_game+1) mod 3` instead. The first round of a session has no `last_game` restriction.
- **LFSR:** 4-bit, x^4+x^3+1, seed 4'b1001 on reset, advances every cycle regardless of state.
- **INTERVAL:** counter runs 0..INTERVAL_CYCLES-1, then go to START. The counter clears on entry.
- **START (1 cycle):** `jogar`=1, then go to RUN.
- **RUN:** watches `pronto[game_sel]`.
  - A registered copy of `pronto` is updated every cycle. A round completes only on a rising edge (cur=1, prev=0) seen while in RUN.
  - A level already high on entry does not complete the round.
  - Edges on non-selected games are ignored.
  - If the RUN counter reaches TIMEOUT_CYCLES-1, set `timeout_flag` and go to SCORE with zero added.
- **SCORE (1 cycle):** `score` += selected `pontuacao` (0 if timed out), zero-extended, saturating at 2^SCORE_W-1. Store `last_game`.
- **CHECK:** go to SELECT if `rodada` < ROUNDS, else go to DONE.
- **DONE:** hold all outputs. `iniciar`=1 restarts the session exactly as from IDLE.
- `iniciar` is ignored in every state other than IDLE and DONE.
- `game_sel` is stable from SELECT through SCORE.

## Timing
- **Reset values:** state IDLE, `game_sel`=0, `jogar`=0, `dificuldade_out`=0, `rodada`=0, `score`=0, `timeout_flag`=0, `sessao_fim`=0, `estado`=0.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- **Latency:** `iniciar` sampled high at edge k gives SELECT at k+1, INTERVAL at k+2, and `jogar` high during cycle k+2+INTERVAL_CYCLES.
- A qualifying `pronto` edge sampled at edge t gives SCORE at t+1, updated `score` visible at t+2, and CHECK at t+2.
- A single round with a game responding in R cycles after `jogar` takes INTERVAL_CYCLES + R + 4 cycles from SELECT to the next SELECT.
- A `pronto` edge and the timeout in the same cycle count as completion: the score is added and `timeout_flag` is not set.
- Reset asserted mid-session returns to IDLE immediately and clears all outputs asynchronously.

## Test plan
Use ROUNDS=3, INTERVAL_CYCLES=4, TIMEOUT_CYCLES=20, SCORE_W=8.
- **Fixed session:** `modo`=0, pulse `iniciar`, answer each `jogar` with a `pronto` edge after 5 cycles, with `pontuacao` = 3, 5, 7. Expect `game_sel` sequence 0,1,2, `rodada` 1..3, `score`=15, `sessao_fim`=1, `timeout_flag`=0.
- **Timeout:** never assert `pronto` in round 2. Expect RUN to last exactly 20 cycles, round 2 to add 0, `timeout_flag`=1 held until the next session start, and final `score` = sum of rounds 1 and 3.
- **Stale/foreign pronto:** hold `pronto[game_sel]`=1 entering RUN and pulse `pronto` of another game. Expect no completion until the selected bit falls and rises again.
- **Random mode:** `modo`=1 across 5 sessions. Expect `game_sel` ∈ {0,1,2} and never equal in consecutive rounds.
- **Saturation:** SCORE_W=3, three rounds scoring 7 each. Expect `score` to stick at 7.
- **Mid-session reset:** assert `reset` during INTERVAL of round 2. Expect all outputs at reset values in the same cycle. A subsequent `iniciar` restarts at `rodada`=1 with `score`=0.

Source files
------------

// File: rtl/round_scheduler_if.sv
// Menu/game-facing signals of the round scheduler, bundled into one port.
// master: menu FSM and game cores; slave: the scheduler.
interface round_scheduler_if #(
  parameter int SCORE_W = 8
);
  logic               iniciar;
  logic               modo;
  logic               dificuldade;
  logic [2:0]         pronto;
  logic [2:0]         pontuacao_0;
  logic [2:0]         pontuacao_1;
  logic [2:0]         pontuacao_2;
  logic [1:0]         game_sel;
  logic               jogar;
  logic               dificuldade_out;
  logic [3:0]         rodada;
  logic [SCORE_W-1:0] score;
  logic               timeout_flag;
  logic               sessao_fim;
  logic [3:0]         estado;

  modport master (
    output iniciar, modo, dificuldade, pronto, pontuacao_0, pontuacao_1, pontuacao_2,
    input  game_sel, jogar, dificuldade_out, rodada, score, timeout_flag, sessao_fim, estado
  );

  modport slave (
    input  iniciar, modo, dificuldade, pronto, pontuacao_0, pontuacao_1, pontuacao_2,
    output game_sel, jogar, dificuldade_out, rodada, score, timeout_flag, sessao_fim, estado
  );
endinterface

// File: rtl/round_scheduler.sv
// Session controller: picks a game per round, waits out the interval, pulses
// jogar, waits for that game's pronto edge or a timeout, and accumulates score.
module round_scheduler #(
  parameter int ROUNDS          = 3,
  parameter int INTERVAL_CYCLES = 2000,
  parameter int TIMEOUT_CYCLES  = 60000,
  parameter int SCORE_W         = 8
) (
  input logic              clock,
  input logic              reset,
  round_scheduler_if.slave bus
);

  localparam int CNT_MAX = (INTERVAL_CYCLES > TIMEOUT_CYCLES) ? INTERVAL_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SUM_W   = ((SCORE_W > 3) ? SCORE_W : 3) + 1;

  localparam logic [CNT_W-1:0] INTERVAL_LAST = CNT_W'(INTERVAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       ROUNDS_L      = 4'(ROUNDS);
  localparam logic [SUM_W-1:0] SCORE_MAX     = SUM_W'({SCORE_W{1'b1}});

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_SELECT   = 4'd1,
    S_INTERVAL = 4'd2,
    S_START    = 4'd3,
    S_RUN      = 4'd4,
    S_SCORE    = 4'd5,
    S_CHECK    = 4'd6,
    S_DONE     = 4'd7
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         rodada_q, rodada_d;
  logic [1:0]         game_sel_q, game_sel_d;
  logic [1:0]         last_game_q, last_game_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               timeout_q, timeout_d;
  logic               timed_out_q, timed_out_d;
  logic               dif_q, dif_d;
  logic               modo_q, modo_d;
  logic [2:0]         pronto_q;

  logic               sel_pronto, sel_prev;
  logic [2:0]         sel_pont;
  logic [1:0]         fixed_game, cand, rand_game;
  logic [SUM_W-1:0]   sum;
  logic [SCORE_W-1:0] score_sat;

  // Per-game mux driven by the registered selection.
  always_comb begin
    sel_pronto = bus.pronto[0];
    sel_prev   = pronto_q[0];
    sel_pont   = bus.pontuacao_0;
    case (game_sel_q)
      2'd1: begin
        sel_pronto = bus.pronto[1];
        sel_prev   = pronto_q[1];
        sel_pont   = bus.pontuacao_1;
      end
      2'd2: begin
        sel_pronto = bus.pronto[2];
        sel_prev   = pronto_q[2];
        sel_pont   = bus.pontuacao_2;
      end
      default: ;
    endcase
  end

  always_comb begin
    fixed_game = (rodada_q == 4'd0) ? 2'd0 : ((game_sel_q == 2'd2) ? 2'd0 : game_sel_q + 2'd1);
    cand       = (lfsr_q[1:0] == 2'd3) ? 2'd0 : lfsr_q[1:0];
    rand_game  = cand;
    if (rodada_q != 4'd0 && cand == last_game_q)
      rand_game = (last_game_q == 2'd2) ? 2'd0 : last_game_q + 2'd1;
    sum       = SUM_W'(score_q) + SUM_W'(sel_pont);
    score_sat = (sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : sum[SCORE_W-1:0];
  end

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case
    // can leave a signal unassigned and infer a latch.
    state_d     = state_q;
    lfsr_d      = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    cnt_d       = cnt_q;
    rodada_d    = rodada_q;
    game_sel_d  = game_sel_q;
    last_game_d = last_game_q;
    score_d     = score_q;
    timeout_d   = timeout_q;
    timed_out_d = timed_out_q;
    dif_d       = dif_q;
    modo_d      = modo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.iniciar) begin
          dif_d       = bus.dificuldade;
          modo_d      = bus.modo;
          score_d     = '0;
          rodada_d    = '0;
          timeout_d   = 1'b0;
          last_game_d = 2'd0;
          state_d     = S_SELECT;
        end
      end
      S_SELECT: begin
        rodada_d   = rodada_q + 4'd1;
        game_sel_d = modo_q ? rand_game : fixed_game;
        cnt_d      = '0;
        state_d    = S_INTERVAL;
      end
      S_INTERVAL: begin
        if (cnt_q == INTERVAL_LAST) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // A completion edge wins over a simultaneous timeout.
        if (sel_pronto && !sel_prev) begin
          timed_out_d = 1'b0;
          state_d     = S_SCORE;
        end else if (cnt_q == RUN_LAST) begin
          timed_out_d = 1'b1;
          timeout_d   = 1'b1;
          state_d     = S_SCORE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SCORE: begin
        if (!timed_out_q) score_d = score_sat;
        last_game_d = game_sel_q;
        state_d     = S_CHECK;
      end
      S_CHECK: state_d = (rodada_q < ROUNDS_L) ? S_SELECT : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= 4'b1001;
      cnt_q       <= '0;
      rodada_q    <= '0;
      game_sel_q  <= 2'd0;
      last_game_q <= 2'd0;
      score_q     <= '0;
      timeout_q   <= 1'b0;
      timed_out_q <= 1'b0;
      dif_q       <= 1'b0;
      modo_q      <= 1'b0;
      pronto_q    <= 3'b000;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      rodada_q    <= rodada_d;
      game_sel_q  <= game_sel_d;
      last_game_q <= last_game_d;
      score_q     <= score_d;
      timeout_q   <= timeout_d;
      timed_out_q <= timed_out_d;
      dif_q       <= dif_d;
      modo_q      <= modo_d;
      pronto_q    <= bus.pronto;
    end
  end

  assign bus.game_sel        = game_sel_q;
  assign bus.jogar           = (state_q == S_START);
  assign bus.dificuldade_out = dif_q;
  assign bus.rodada          = rodada_q;
  assign bus.score           = score_q;
  assign bus.timeout_flag    = timeout_q;
  assign bus.sessao_fim      = (state_q == S_DONE);
  assign bus.estado          = state_q;

endmodule

// File: tb/tb_round_scheduler.sv
// Scoreboard bench: sessions push expected per-round and end-of-session
// records; a monitor pops them on each jogar pulse and each session end.
module tb_round_scheduler;
  localparam int INTERVAL = 4;
  localparam int TIMEOUT  = 20;

  typedef enum int {R_NORMAL, R_SILENT, R_STALE, R_EDGE_TO} rkind_t;

  typedef struct {
    logic [1:0] game;
    bit         rnd;
    logic [3:0] rodada;
    int         gap;
    logic [7:0] score;
    logic       tflag;
    logic       dif;
  } round_exp_t;

  typedef struct {
    logic [7:0] score;
    logic [2:0] score_s;
    logic       tflag;
  } end_exp_t;

  logic clock, reset;
  int   cyc = 0;
  int   sess_start_cyc = 0;
  int   n_vec = 0, n_miss = 0;
  logic [2:0] pont_v [3];

  round_exp_t round_q[$];
  end_exp_t   end_q[$];

  round_scheduler_if #(.SCORE_W(8)) bus ();
  round_scheduler_if #(.SCORE_W(3)) bus_s ();

  round_scheduler #(.ROUNDS(3), .INTERVAL_CYCLES(INTERVAL), .TIMEOUT_CYCLES(TIMEOUT), .SCORE_W(8))
    dut (.clock(clock), .reset(reset), .bus(bus));

  round_scheduler #(.ROUNDS(3), .INTERVAL_CYCLES(INTERVAL), .TIMEOUT_CYCLES(TIMEOUT), .SCORE_W(3))
    dut_s (.clock(clock), .reset(reset), .bus(bus_s));

  assign bus_s.iniciar     = bus.iniciar;
  assign bus_s.modo        = bus.modo;
  assign bus_s.dificuldade = bus.dificuldade;
  assign bus_s.pronto      = bus.pronto;
  assign bus_s.pontuacao_0 = bus.pontuacao_0;
  assign bus_s.pontuacao_1 = bus.pontuacao_1;
  assign bus_s.pontuacao_2 = bus.pontuacao_2;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 20000 cycles");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int run_len(input rkind_t k);
    case (k)
      R_NORMAL: return 5;
      R_STALE:  return 6;
      default:  return TIMEOUT;
    endcase
  endfunction

  task automatic set_pont(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    pont_v[0] = a; pont_v[1] = b; pont_v[2] = c;
    bus.pontuacao_0 = a; bus.pontuacao_1 = b; bus.pontuacao_2 = c;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_estado"},       32'(bus.estado), 0);
    check({tag, "_game_sel"},     32'(bus.game_sel), 0);
    check({tag, "_jogar"},        32'(bus.jogar), 0);
    check({tag, "_dif_out"},      32'(bus.dificuldade_out), 0);
    check({tag, "_rodada"},       32'(bus.rodada), 0);
    check({tag, "_score"},        32'(bus.score), 0);
    check({tag, "_timeout_flag"}, 32'(bus.timeout_flag), 0);
    check({tag, "_sessao_fim"},   32'(bus.sessao_fim), 0);
    check({tag, "_score_sat"},    32'(bus_s.score), 0);
  endtask

  task automatic wait_jogar(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.jogar) begin
        ok = 1'b1;
        break;
      end
    end
    check("jogar_seen", 32'(ok), 1);
  endtask

  task automatic wait_fim();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.sessao_fim) begin
        ok = 1'b1;
        break;
      end
    end
    check("sessao_fim_seen", 32'(ok), 1);
    repeat (3) @(negedge clock);
    check("done_hold_estado", 32'(bus.estado), 7);
    check("done_hold_rodada", 32'(bus.rodada), 3);
  endtask

  // Plays the selected game's side of one round, starting at the negedge of START.
  task automatic respond(input rkind_t k, input logic [1:0] g);
    int gi, oi;
    gi = int'(g);
    oi = (gi + 1) % 3;
    case (k)
      R_NORMAL, R_EDGE_TO: begin
        repeat ((k == R_NORMAL) ? 5 : TIMEOUT) @(negedge clock);
        bus.pronto[gi] = 1'b1;
        @(negedge clock);
        bus.pronto[gi] = 1'b0;
      end
      R_STALE: begin
        @(negedge clock); bus.pronto[oi] = 1'b1;
        @(negedge clock); bus.pronto[oi] = 1'b0;
        @(negedge clock); bus.pronto[gi] = 1'b0;
        repeat (3) @(negedge clock);
        bus.pronto[gi] = 1'b1;
        @(negedge clock); bus.pronto[gi] = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic run_session(input bit m, input bit d, input rkind_t k0, input rkind_t k1,
                             input rkind_t k2, input int exp_score, input int exp_sat,
                             input bit exp_to);
    rkind_t kinds [3];
    int acc, prev_run, gi;
    bit to, ok;
    kinds[0] = k0; kinds[1] = k1; kinds[2] = k2;
    acc = 0; prev_run = 0; to = 1'b0;
    bus.modo = m;
    bus.dificuldade = d;
    if (k0 == R_STALE) bus.pronto = 3'b001;
    @(negedge clock);
    bus.iniciar = 1'b1;
    sess_start_cyc = cyc;
    end_q.push_back('{score: 8'(exp_score), score_s: 3'(exp_sat), tflag: exp_to});
    @(negedge clock);
    bus.iniciar = 1'b0;
    bus.dificuldade = ~d;
    for (int r = 0; r < 3; r++) begin
      gi = m ? 0 : r;
      round_q.push_back('{game: 2'(r), rnd: m, rodada: 4'(r + 1),
                          gap: (r == 0) ? INTERVAL + 2 : prev_run + 4 + INTERVAL,
                          score: 8'(acc), tflag: to, dif: d});
      wait_jogar(ok);
      if (!ok) return;
      respond(kinds[r], bus.game_sel);
      if (kinds[r] == R_SILENT) to = 1'b1;
      else acc += int'(pont_v[gi]);
      prev_run = run_len(kinds[r]);
    end
    wait_fim();
    bus.pronto = 3'b000;
  endtask

  task automatic mid_reset();
    bit ok;
    set_pont(3'd3, 3'd5, 3'd7);
    bus.modo = 1'b0;
    bus.dificuldade = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b1;
    sess_start_cyc = cyc;
    round_q.push_back('{game: 2'd0, rnd: 1'b0, rodada: 4'd1, gap: INTERVAL + 2,
                        score: 8'd0, tflag: 1'b0, dif: 1'b1});
    @(negedge clock);
    bus.iniciar = 1'b0;
    wait_jogar(ok);
    if (ok) respond(R_NORMAL, 2'd0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.estado == 4'd2 && bus.rodada == 4'd2) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_round2_interval", 32'(ok), 1);
    check("pre_reset_score", 32'(bus.score), 3);
    #2 reset = 1'b1;
    #1 check_reset_values("midreset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: pops expectations when the DUT presents jogar or enters DONE.
  initial begin : monitor
    logic fim_prev;
    logic [1:0] prev_g;
    int last_jogar, gap;
    round_exp_t rr;
    end_exp_t er;
    fim_prev = 1'b0;
    prev_g = 2'd0;
    last_jogar = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        fim_prev = 1'b0;
        continue;
      end
      if (bus.jogar) begin
        if (round_q.size() == 0) begin
          check("unexpected_jogar", 1, 0);
        end else begin
          rr = round_q.pop_front();
          gap = (rr.rodada == 4'd1) ? cyc - sess_start_cyc : cyc - last_jogar;
          check("jogar_gap", 32'(gap), 32'(rr.gap));
          check("rodada", 32'(bus.rodada), 32'(rr.rodada));
          if (rr.rnd) begin
            check("rand_range", 32'(bus.game_sel < 2'd3), 1);
            if (rr.rodada != 4'd1) check("rand_repeat", 32'(bus.game_sel != prev_g), 1);
          end else begin
            check("game_sel", 32'(bus.game_sel), 32'(rr.game));
          end
          check("score_before", 32'(bus.score), 32'(rr.score));
          check("tflag_before", 32'(bus.timeout_flag), 32'(rr.tflag));
          check("dif_out", 32'(bus.dificuldade_out), 32'(rr.dif));
          prev_g = bus.game_sel;
          last_jogar = cyc;
        end
      end
      if (bus.sessao_fim && !fim_prev) begin
        if (end_q.size() == 0) begin
          check("unexpected_sessao_fim", 1, 0);
        end else begin
          er = end_q.pop_front();
          check("end_score", 32'(bus.score), 32'(er.score));
          check("end_score_sat", 32'(bus_s.score), 32'(er.score_s));
          check("end_timeout_flag", 32'(bus.timeout_flag), 32'(er.tflag));
          check("end_rodada", 32'(bus.rodada), 3);
        end
      end
      fim_prev = bus.sessao_fim;
    end
  end

  initial begin : stimulus
    reset = 1'b1;
    bus.iniciar = 1'b0;
    bus.modo = 1'b0;
    bus.dificuldade = 1'b0;
    bus.pronto = 3'b000;
    set_pont(3'd3, 3'd5, 3'd7);
    repeat (2) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    run_session(1'b0, 1'b0, R_NORMAL, R_NORMAL,  R_NORMAL, 15, 7, 1'b0);
    run_session(1'b0, 1'b1, R_NORMAL, R_SILENT,  R_NORMAL, 10, 7, 1'b1);
    run_session(1'b0, 1'b0, R_STALE,  R_NORMAL,  R_NORMAL, 15, 7, 1'b0);
    run_session(1'b0, 1'b1, R_NORMAL, R_EDGE_TO, R_NORMAL, 15, 7, 1'b0);
    set_pont(3'd7, 3'd7, 3'd7);
    run_session(1'b0, 1'b0, R_NORMAL, R_NORMAL,  R_NORMAL, 21, 7, 1'b0);
    set_pont(3'd2, 3'd2, 3'd2);
    for (int s = 0; s < 5; s++)
      run_session(1'b1, (s % 2) != 0, R_NORMAL, R_NORMAL, R_NORMAL, 6, 6, 1'b0);
    mid_reset();
    set_pont(3'd3, 3'd5, 3'd7);
    run_session(1'b0, 1'b0, R_NORMAL, R_NORMAL,  R_NORMAL, 15, 7, 1'b0);

    repeat (2) @(negedge clock);
    check("round_q_drained", 32'(round_q.size()), 0);
    check("end_q_drained", 32'(end_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
